// File: rtl/fetch_control_unit_pkg.sv
// Shared MIPS-lite constants: opcodes, NOP, PC width and fetch FSM encodings.
// Also imported by the stall control block, so existing values must stay fixed.
package mips_pkg;
  localparam int PC_W = 8;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [31:0]     instr_t;

  localparam logic [5:0] OP_HLT = 6'b010001;
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_JMP = 6'b011110;
  localparam instr_t     NOP    = 32'h0000_0000;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic is_op(input instr_t instr, input logic [5:0] op);
    return instr[31:26] == op;
  endfunction
endpackage

// File: rtl/fetch_control_unit_if.sv
// Fetch-stage bundle: stall/jump controls and program memory data in; pc, ir and status out.
interface fetch_control_unit_if;
  import mips_pkg::*;

  logic   stall;
  logic   stall_pm;
  logic   jump_en;
  pc_t    jump_addr;
  instr_t instr_in;
  pc_t    pc;
  instr_t ir;
  logic   ir_valid;
  logic   halted;

  modport master (
    output stall, stall_pm, jump_en, jump_addr, instr_in,
    input  pc, ir, ir_valid, halted
  );

  modport slave (
    input  stall, stall_pm, jump_en, jump_addr, instr_in,
    output pc, ir, ir_valid, halted
  );
endinterface

// File: rtl/fetch_control_unit_pc_counter.sv
// Program counter register: load beats increment, otherwise holds; wraps modulo 256.
// One-cycle update, no backpressure of its own.
module pc_counter
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  pc_t  load_val,
  output pc_t  pc
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + pc_t'(1);
  end
endmodule

// File: rtl/fetch_control_unit.sv
// Fetch stage: RUN/HOLD/HALT FSM driving pc, ir and a one-entry replay register; ir lags pc by one cycle.
// stall freezes pc and injects bubbles, stall_pm replays the last fetch, jump_en overrides both.
module fetch_control_unit
  import mips_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  fetch_control_unit_if.slave bus
);
  logic [1:0] state, state_nxt;
  instr_t     replay, replay_nxt, ir_nxt;
  logic       vld_nxt, pc_load, pc_inc, hlt_retire;

  assign hlt_retire = bus.ir_valid && is_op(bus.ir, OP_HLT);

  // HLT retiring from ir takes priority over everything, including a same-cycle jump.
  always_comb begin
    state_nxt  = state;
    replay_nxt = replay;
    ir_nxt     = NOP;
    vld_nxt    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    if (state == ST_HALT || hlt_retire) begin
      state_nxt = ST_HALT;
    end else if (bus.jump_en) begin
      state_nxt = ST_RUN;
      pc_load   = 1'b1;
    end else if (bus.stall) begin
      state_nxt = ST_HOLD;
    end else begin
      state_nxt = ST_RUN;
      vld_nxt   = 1'b1;
      if (bus.stall_pm) begin
        // Replay from RUN re-presents the old word without advancing; leaving HOLD still advances.
        ir_nxt = replay;
        pc_inc = (state == ST_HOLD);
      end else begin
        ir_nxt     = bus.instr_in;
        replay_nxt = bus.instr_in;
        pc_inc     = 1'b1;
      end
    end
  end

  pc_counter u_pc_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (bus.jump_addr),
    .pc       (bus.pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      bus.ir       <= NOP;
      bus.ir_valid <= 1'b0;
      bus.halted   <= 1'b0;
      replay       <= NOP;
    end else begin
      state        <= state_nxt;
      bus.ir       <= ir_nxt;
      bus.ir_valid <= vld_nxt;
      bus.halted   <= (state_nxt == ST_HALT);
      replay       <= replay_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit with a rule-level reference model checked every cycle.
module tb_fetch_control_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_control_unit_if bus ();

  fetch_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  instr_t mem [256];
  assign bus.instr_in = mem[bus.pc];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ir;
    logic        vld;
    logic        halt;
    logic        hold;
    logic [31:0] replay;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input logic st, input logic spm,
                                   input logic jmp, input logic [7:0] ja);
    mstate_t n;
    n = s;
    n.ir  = NOP;
    n.vld = 1'b0;
    if (s.halt || (s.vld && s.ir[31:26] == OP_HLT)) begin
      n.halt = 1'b1;
    end else if (jmp) begin
      n.pc   = ja;
      n.hold = 1'b0;
    end else if (st) begin
      n.hold = 1'b1;
    end else if (spm) begin
      n.ir   = s.replay;
      n.vld  = 1'b1;
      n.hold = 1'b0;
      if (s.hold) n.pc = s.pc + 8'd1;
    end else begin
      n.ir     = mem[s.pc];
      n.replay = mem[s.pc];
      n.vld    = 1'b1;
      n.hold   = 1'b0;
      n.pc     = s.pc + 8'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= step(m, bus.stall, bus.stall_pm, bus.jump_en, bus.jump_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("model_pc", 32'(bus.pc), 32'(m.pc));
      chk("model_ir", bus.ir, m.ir);
      chk("model_ir_valid", 32'(bus.ir_valid), 32'(m.vld));
      chk("model_halted", 32'(bus.halted), 32'(m.halt));
    end
  end

  task automatic drive(input logic st, input logic spm, input logic jmp, input logic [7:0] ja);
    bus.stall     = st;
    bus.stall_pm  = spm;
    bus.jump_en   = jmp;
    bus.jump_addr = ja;
  endtask

  task automatic cyc(input logic st, input logic spm, input logic jmp, input logic [7:0] ja);
    drive(st, spm, jmp, ja);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = instr_t'(a);
    mem[8'h05] = {OP_LD, 26'h4};
    mem[8'h20] = {OP_HLT, 26'h0};
    mem[8'h42] = {OP_JMP, 26'h3};
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    #1 reset = 1'b0;
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    #1 reset = 1'b1;

    @(negedge clk);
    chk("edge1_pc", 32'(bus.pc), 32'h1);
    chk("edge1_ir_valid", 32'(bus.ir_valid), 32'h1);
    cyc(0, 0, 0, 8'h00);
    chk("edge2_pc", 32'(bus.pc), 32'h2);
    chk("edge2_ir", bus.ir, 32'h1);
    repeat (4) cyc(0, 0, 0, 8'h00);
    chk("ld_in_ir", bus.ir, 32'h5000_0004);

    cyc(1, 0, 0, 8'h00);
    chk("stall1_pc", 32'(bus.pc), 32'h6);
    chk("stall1_bubble", bus.ir, 32'h0);
    cyc(1, 0, 0, 8'h00);
    chk("stall2_pc", 32'(bus.pc), 32'h6);
    chk("stall2_valid", 32'(bus.ir_valid), 32'h0);
    cyc(0, 1, 0, 8'h00);
    chk("replay_ir", bus.ir, 32'h5000_0004);
    chk("replay_valid", 32'(bus.ir_valid), 32'h1);
    chk("replay_instr_in", bus.instr_in, 32'h7);
    chk("resume_pc", 32'(bus.pc), 32'h7);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    chk("run_replay_pc_hold", 32'(bus.pc), 32'h8);
    chk("run_replay_ir", bus.ir, 32'h7);

    cyc(1, 1, 1, 8'h40);
    chk("jump_pc", 32'(bus.pc), 32'h40);
    chk("jump_ir", bus.ir, 32'h0);
    cyc(0, 0, 0, 8'h00);
    chk("post_jump_pc", 32'(bus.pc), 32'h41);
    chk("post_jump_ir", bus.ir, 32'h40);
    cyc(1, 1, 0, 8'h00);
    chk("stall_beats_pm_pc", 32'(bus.pc), 32'h41);
    chk("stall_beats_pm_valid", 32'(bus.ir_valid), 32'h0);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    cyc(0, 0, 1, 8'hFE);
    cyc(0, 0, 0, 8'h00);
    chk("pc_ff", 32'(bus.pc), 32'hFF);
    cyc(0, 0, 0, 8'h00);
    chk("pc_wrap", 32'(bus.pc), 32'h0);
    chk("wrap_ir", bus.ir, 32'hFF);

    cyc(0, 0, 1, 8'h20);
    cyc(0, 0, 0, 8'h00);
    chk("hlt_in_ir", bus.ir, 32'h4400_0000);
    chk("hlt_not_yet", 32'(bus.halted), 32'h0);
    cyc(0, 0, 1, 8'h80);
    chk("halted_set", 32'(bus.halted), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h21);
    repeat (2) cyc(1, 1, 1, 8'h80);
    chk("halt_pc_frozen", 32'(bus.pc), 32'h21);
    chk("halt_sticky", 32'(bus.halted), 32'h1);

    drive(0, 0, 0, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("halt_rst_pc", 32'(bus.pc), 32'h0);
    chk("halt_rst_halted", 32'(bus.halted), 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("after_halt_rst_pc", 32'(bus.pc), 32'h1);
    chk("after_halt_rst_ir", bus.ir, 32'h0);

    cyc(1, 0, 0, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("stall_rst_pc", 32'(bus.pc), 32'h0);
    drive(0, 0, 0, 8'h00);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("stall_rst_first_pc", 32'(bus.pc), 32'h1);
    chk("stall_rst_first_valid", 32'(bus.ir_valid), 32'h1);
    repeat (3) cyc(0, 0, 0, 8'h00);
    chk("final_pc", 32'(bus.pc), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
